// File: rtl/bram_pkg.sv
// bram_pkg -- shared constants and helpers for the dual-port block RAM.
//
// Contents:
//   RD_FIRST / WR_FIRST : values for the RD_MODE parameter (same-port
//                         read-during-write returns old / new data)
//   bytes_of()          : number of byte lanes in a word of a given width
//
// Optional feature macro used by this block: BRAM_DP_COLLISION_EN
package bram_pkg;

  localparam int RD_FIRST = 0;
  localparam int WR_FIRST = 1;

  function automatic int bytes_of(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/bram_dp_if.sv
// bram_dp_if -- bus bundle for both ports of bram_dp.
//
// Signals (x = A or B):
//   ENx    enable, one access per enabled cycle
//   WEx    per-byte write enables, bit i covers byte i
//   ADDRx  32-bit word address, only the low ADDR_W bits are used
//   DIx    write data
//   DOx    read data
//   VLDx   DOx carries data from an enabled access
//
// Modports: master drives requests and takes read data; slave is the RAM.
interface bram_dp_if
  import bram_pkg::*;
#(
  parameter int DATA_W = 32
);

  localparam int BYTES = bytes_of(DATA_W);

  logic              ENA;
  logic              ENB;
  logic [BYTES-1:0]  WEA;
  logic [BYTES-1:0]  WEB;
  logic [31:0]       ADDRA;
  logic [31:0]       ADDRB;
  logic [DATA_W-1:0] DIA;
  logic [DATA_W-1:0] DIB;
  logic [DATA_W-1:0] DOA;
  logic [DATA_W-1:0] DOB;
  logic              VLDA;
  logic              VLDB;

  modport master (
    output ENA, ENB, WEA, WEB, ADDRA, ADDRB, DIA, DIB,
    input  DOA, DOB, VLDA, VLDB
  );

  modport slave (
    input  ENA, ENB, WEA, WEB, ADDRA, ADDRB, DIA, DIB,
    output DOA, DOB, VLDA, VLDB
  );

endinterface

// File: rtl/bram_dp_oport.sv
// bram_dp_oport -- output stage for one port of bram_dp.
//
// Ports:
//   CLK    clock, rising edge
//   RST_N  asynchronous active-low reset
//   en     port enable as presented with the access
//   ram_q  raw array read register (no reset, holds its value when idle)
//   dout   read data, forced to zero for disabled accesses and in reset
//   vld    dout carries data from an enabled access
//
// OUT_REG = 0 gives read latency 1, OUT_REG = 1 adds one register stage.
module bram_dp_oport #(
  parameter int DATA_W  = 32,
  parameter int OUT_REG = 0
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              en,
  input  logic [DATA_W-1:0] ram_q,
  output logic [DATA_W-1:0] dout,
  output logic              vld
);

  logic              vld_s1;
  logic [DATA_W-1:0] data_s1;

  // The array's read register has no reset, so the valid bit doubles as
  // the data mask: it clears asynchronously, which zeroes the output at
  // once on reset and whenever the access was disabled.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) vld_s1 <= 1'b0;
    else        vld_s1 <= en;
  end

  assign data_s1 = vld_s1 ? ram_q : '0;

  if (OUT_REG != 0) begin : g_out_reg
    logic [DATA_W-1:0] data_s2;
    logic              vld_s2;

    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        data_s2 <= '0;
        vld_s2  <= 1'b0;
      end else begin
        data_s2 <= data_s1;
        vld_s2  <= vld_s1;
      end
    end

    assign dout = data_s2;
    assign vld  = vld_s2;
  end else begin : g_no_out_reg
    assign dout = data_s1;
    assign vld  = vld_s1;
  end

endmodule

// File: rtl/bram_dp.sv
// bram_dp -- true dual-port block RAM with byte write enables.
//
// Ports:
//   CLK    sole clock, rising edge
//   RST_N  asynchronous active-low reset (clears outputs and pipeline,
//          never the array contents; blocks writes while low)
//   bus    bram_dp_if.slave, ports A and B
//   COLL   only with BRAM_DP_COLLISION_EN: one-cycle pulse after a cycle in
//          which both ports hit the same address and at least one writes
//
// Parameters: DATA_W (multiple of 8), ADDR_W (depth 2**ADDR_W),
// OUT_REG (0: latency 1, 1: latency 2), RD_MODE (RD_FIRST / WR_FIRST).
// Optional feature macro: BRAM_DP_COLLISION_EN.
module bram_dp
  import bram_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 13,
  parameter int OUT_REG = 0,
  parameter int RD_MODE = RD_FIRST
) (
  input  logic      CLK,
  input  logic      RST_N,
  bram_dp_if.slave  bus
`ifdef BRAM_DP_COLLISION_EN
  ,
  output logic      COLL
`endif
);

  localparam int BYTES = bytes_of(DATA_W);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] addr_a;
  logic [ADDR_W-1:0] addr_b;
  logic [DATA_W-1:0] ram_a;
  logic [DATA_W-1:0] ram_b;
  logic              unused_addr_bits;

  // Upper address bits simply alias onto the array.
  assign addr_a = bus.ADDRA[ADDR_W-1:0];
  assign addr_b = bus.ADDRB[ADDR_W-1:0];
  assign unused_addr_bits = ^{bus.ADDRA[31:ADDR_W], bus.ADDRB[31:ADDR_W]};

  // Array and its read registers, kept free of reset for BRAM inference.
  // Reads take the pre-edge array word, so the other port's write is never
  // seen in the same cycle; write-first only merges a port's own bytes.
  // Port A's writes are issued after port B's so A wins a shared byte.
  always_ff @(posedge CLK) begin
    if (RST_N) begin
      if (bus.ENA) begin
        for (int b = 0; b < BYTES; b++) begin
          if (RD_MODE == WR_FIRST && bus.WEA[b]) ram_a[8*b +: 8] <= bus.DIA[8*b +: 8];
          else                                   ram_a[8*b +: 8] <= mem[addr_a][8*b +: 8];
        end
      end
      if (bus.ENB) begin
        for (int b = 0; b < BYTES; b++) begin
          if (RD_MODE == WR_FIRST && bus.WEB[b]) ram_b[8*b +: 8] <= bus.DIB[8*b +: 8];
          else                                   ram_b[8*b +: 8] <= mem[addr_b][8*b +: 8];
        end
      end
      if (bus.ENB) begin
        for (int b = 0; b < BYTES; b++) begin
          if (bus.WEB[b]) mem[addr_b][8*b +: 8] <= bus.DIB[8*b +: 8];
        end
      end
      if (bus.ENA) begin
        for (int b = 0; b < BYTES; b++) begin
          if (bus.WEA[b]) mem[addr_a][8*b +: 8] <= bus.DIA[8*b +: 8];
        end
      end
    end
  end

  bram_dp_oport #(.DATA_W(DATA_W), .OUT_REG(OUT_REG)) u_oport_a (
    .CLK   (CLK),
    .RST_N (RST_N),
    .en    (bus.ENA),
    .ram_q (ram_a),
    .dout  (bus.DOA),
    .vld   (bus.VLDA)
  );

  bram_dp_oport #(.DATA_W(DATA_W), .OUT_REG(OUT_REG)) u_oport_b (
    .CLK   (CLK),
    .RST_N (RST_N),
    .en    (bus.ENB),
    .ram_q (ram_b),
    .dout  (bus.DOB),
    .vld   (bus.VLDB)
  );

`ifdef BRAM_DP_COLLISION_EN
  // Flag any same-address cycle with both ports enabled and a write.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) COLL <= 1'b0;
    else        COLL <= bus.ENA && bus.ENB && (addr_a == addr_b) &&
                        ((|bus.WEA) || (|bus.WEB));
  end
`endif

endmodule

// File: tb/tb_bram_dp.sv
// tb_bram_dp -- directed self-checking bench for bram_dp.
//
// Five instances share one stimulus stream:
//   k=0..3 : DATA_W=32, ADDR_W=13, OUT_REG=k%2, RD_MODE=k/2
//   k=4    : DATA_W=64, ADDR_W=4,  OUT_REG=1,   RD_MODE=1 (wraps at 16)
// Expected values are written out per scenario; each instance's latency
// and read mode select the one that applies.
// Optional feature macro checked when defined: BRAM_DP_COLLISION_EN.
module tb_bram_dp;

  localparam int N = 5;

  logic        clk;
  logic        rst_n;
  logic        ena, enb;
  logic [7:0]  wea, web;
  logic [31:0] addra, addrb;
  logic [63:0] dia, dib;
  logic [63:0] doa [N];
  logic [63:0] dob [N];
  logic [N-1:0] vlda, vldb;
`ifdef BRAM_DP_COLLISION_EN
  logic [N-1:0] coll;
`endif

  logic [63:0] cap_doa [N];
  logic [63:0] cap_dob [N];
  logic        cap_vlda [N];
  logic        cap_vldb [N];

  int checks;
  int failures;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar k = 0; k < N; k++) begin : g_dut
    localparam int DW = (k == 4) ? 64 : 32;
    localparam int AW = (k == 4) ? 4 : 13;
    localparam int OR = (k == 4) ? 1 : (k % 2);
    localparam int RM = (k == 4) ? 1 : (k / 2);

    bram_dp_if #(.DATA_W(DW)) bus ();

    assign bus.ENA   = ena;
    assign bus.ENB   = enb;
    assign bus.WEA   = wea[DW/8-1:0];
    assign bus.WEB   = web[DW/8-1:0];
    assign bus.ADDRA = addra;
    assign bus.ADDRB = addrb;
    assign bus.DIA   = dia[DW-1:0];
    assign bus.DIB   = dib[DW-1:0];
    assign doa[k]    = 64'(bus.DOA);
    assign dob[k]    = 64'(bus.DOB);
    assign vlda[k]   = bus.VLDA;
    assign vldb[k]   = bus.VLDB;

    bram_dp #(.DATA_W(DW), .ADDR_W(AW), .OUT_REG(OR), .RD_MODE(RM)) dut (
      .CLK   (clk),
      .RST_N (rst_n),
      .bus   (bus)
`ifdef BRAM_DP_COLLISION_EN
      ,
      .COLL  (coll[k])
`endif
    );
  end

  function automatic int lat(input int k);
    return (k == 4) ? 2 : 1 + (k % 2);
  endfunction

  function automatic bit wr_first(input int k);
    return (k == 4) ? 1'b1 : (k / 2 != 0);
  endfunction

  function automatic logic [63:0] pat(input int i);
    return 64'h0000_0000_A500_0000 | (64'(i) << 8) | 64'(i);
  endfunction

  // One access: drive after a falling edge, go idle just after the rising edge.
  task automatic access(input logic ea, input logic [7:0] wa, input logic [31:0] aa,
                        input logic [63:0] da, input logic eb, input logic [7:0] wb,
                        input logic [31:0] ab, input logic [63:0] db);
    @(negedge clk);
    ena = ea; wea = wa; addra = aa; dia = da;
    enb = eb; web = wb; addrb = ab; dib = db;
    @(posedge clk);
    #1;
    ena = 1'b0; wea = '0; enb = 1'b0; web = '0;
  endtask

  // Grab each instance's outputs at the falling edge matching its latency.
  task automatic capture();
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      if (lat(k) == 1) begin
        cap_doa[k] = doa[k]; cap_dob[k] = dob[k];
        cap_vlda[k] = vlda[k]; cap_vldb[k] = vldb[k];
      end
    end
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      if (lat(k) == 2) begin
        cap_doa[k] = doa[k]; cap_dob[k] = dob[k];
        cap_vlda[k] = vlda[k]; cap_vldb[k] = vldb[k];
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    ena = 1'b0; enb = 1'b0; wea = '0; web = '0;
    addra = '0; addrb = '0; dia = '0; dib = '0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < N; k++) begin
      checks++;
      if ({doa[k], dob[k], vlda[k], vldb[k]} !== '0) begin
        failures++;
        $display("[TB] FAIL reset_outputs inst=%0d got doa=%h dob=%h vlda=%b vldb=%b want all 0",
                 k, doa[k], dob[k], vlda[k], vldb[k]);
      end
    end
`ifdef BRAM_DP_COLLISION_EN
    checks++;
    if (coll !== '0) begin
      failures++;
      $display("[TB] FAIL reset_coll got %b want 0", coll);
    end
`endif
    rst_n = 1'b1;
  endtask

  task automatic test_write_read();
    access(1'b1, 8'hFF, 32'h10, 64'hDEAD_BEEF, 1'b0, 8'h00, 32'h0, 64'h0);
    access(1'b0, 8'h00, 32'h0, 64'h0, 1'b1, 8'h00, 32'h10, 64'h0);
    capture();
    for (int k = 0; k < N; k++) begin
      checks++;
      if (cap_dob[k] !== 64'hDEAD_BEEF || cap_vldb[k] !== 1'b1) begin
        failures++;
        $display("[TB] FAIL write_read inst=%0d got dob=%h vldb=%b want DEADBEEF/1",
                 k, cap_dob[k], cap_vldb[k]);
      end
      checks++;
      if (cap_doa[k] !== 64'h0 || cap_vlda[k] !== 1'b0) begin
        failures++;
        $display("[TB] FAIL idle_port_a inst=%0d got doa=%h vlda=%b want 0/0",
                 k, cap_doa[k], cap_vlda[k]);
      end
    end
  endtask

  task automatic test_same_port();
    logic [63:0] exp;
    access(1'b1, 8'hFF, 32'h5, 64'h1122_3344, 1'b0, 8'h00, 32'h0, 64'h0);
    access(1'b1, 8'h03, 32'h5, 64'hAAAA_BBBB, 1'b0, 8'h00, 32'h0, 64'h0);
    capture();
    for (int k = 0; k < N; k++) begin
      exp = wr_first(k) ? 64'h1122_BBBB : 64'h1122_3344;
      checks++;
      if (cap_doa[k] !== exp || cap_vlda[k] !== 1'b1) begin
        failures++;
        $display("[TB] FAIL same_port_rdw inst=%0d got doa=%h vlda=%b want %h/1",
                 k, cap_doa[k], cap_vlda[k], exp);
      end
    end
    access(1'b1, 8'h00, 32'h5, 64'h0, 1'b0, 8'h00, 32'h0, 64'h0);
    capture();
    for (int k = 0; k < N; k++) begin
      checks++;
      if (cap_doa[k] !== 64'h1122_BBBB) begin
        failures++;
        $display("[TB] FAIL byte_merge inst=%0d got doa=%h want 1122BBBB", k, cap_doa[k]);
      end
    end
  endtask

  task automatic test_cross_port();
    access(1'b1, 8'hFF, 32'h5, 64'h5566_7788, 1'b1, 8'h00, 32'h5, 64'h0);
    capture();
    for (int k = 0; k < N; k++) begin
      checks++;
      if (cap_dob[k] !== 64'h1122_BBBB || cap_vldb[k] !== 1'b1) begin
        failures++;
        $display("[TB] FAIL cross_port_old inst=%0d got dob=%h vldb=%b want 1122BBBB/1",
                 k, cap_dob[k], cap_vldb[k]);
      end
    end
    access(1'b0, 8'h00, 32'h0, 64'h0, 1'b1, 8'h00, 32'h5, 64'h0);
    capture();
    for (int k = 0; k < N; k++) begin
      checks++;
      if (cap_dob[k] !== 64'h5566_7788) begin
        failures++;
        $display("[TB] FAIL cross_port_new inst=%0d got dob=%h want 55667788", k, cap_dob[k]);
      end
    end
  endtask

  task automatic test_collision();
    access(1'b1, 8'hFF, 32'h7, 64'h0, 1'b0, 8'h00, 32'h0, 64'h0);
    access(1'b1, 8'h01, 32'h7, 64'h0000_00AA, 1'b1, 8'h03, 32'h7, 64'h0000_CCDD);
    @(negedge clk);
`ifdef BRAM_DP_COLLISION_EN
    checks++;
    if (coll !== '1) begin
      failures++;
      $display("[TB] FAIL coll_pulse got %b want 11111", coll);
    end
`endif
    @(negedge clk);
`ifdef BRAM_DP_COLLISION_EN
    checks++;
    if (coll !== '0) begin
      failures++;
      $display("[TB] FAIL coll_clear got %b want 00000", coll);
    end
`endif
    access(1'b1, 8'h00, 32'h7, 64'h0, 1'b0, 8'h00, 32'h0, 64'h0);
    capture();
    for (int k = 0; k < N; k++) begin
      checks++;
      if (cap_doa[k] !== 64'h0000_CCAA) begin
        failures++;
        $display("[TB] FAIL dual_write inst=%0d got doa=%h want 0000CCAA", k, cap_doa[k]);
      end
    end
  endtask

  task automatic test_disable_alias();
    access(1'b0, 8'h00, 32'h5, 64'h0, 1'b0, 8'h00, 32'h0, 64'h0);
    capture();
    for (int k = 0; k < N; k++) begin
      checks++;
      if (cap_doa[k] !== 64'h0 || cap_vlda[k] !== 1'b0) begin
        failures++;
        $display("[TB] FAIL disabled_read inst=%0d got doa=%h vlda=%b want 0/0",
                 k, cap_doa[k], cap_vlda[k]);
      end
    end
    access(1'b1, 8'h00, 32'h2005, 64'h0, 1'b0, 8'h00, 32'h0, 64'h0);
    capture();
    for (int k = 0; k < N; k++) begin
      checks++;
      if (cap_doa[k] !== 64'h5566_7788 || cap_vlda[k] !== 1'b1) begin
        failures++;
        $display("[TB] FAIL addr_alias inst=%0d got doa=%h vlda=%b want 55667788/1",
                 k, cap_doa[k], cap_vlda[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] exp;
    logic        expv;
    for (int i = 0; i < 16; i++) begin
      access(1'b0, 8'h00, 32'h0, 64'h0, 1'b1, 8'hFF, 32'(i), pat(i));
    end
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      ena = 1'b1; wea = '0; addra = 32'(i);
      @(posedge clk);
      @(negedge clk);
      for (int k = 0; k < N; k++) begin
        if (lat(k) == 1)  begin exp = pat(i);     expv = 1'b1; end
        else if (i == 0)  begin exp = 64'h0;      expv = 1'b0; end
        else              begin exp = pat(i - 1); expv = 1'b1; end
        checks++;
        if (doa[k] !== exp || vlda[k] !== expv) begin
          failures++;
          $display("[TB] FAIL stream i=%0d inst=%0d got doa=%h vlda=%b want %h/%b",
                   i, k, doa[k], vlda[k], exp, expv);
        end
      end
    end
    ena = 1'b0;
  endtask

  task automatic test_reset_mid_stream();
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      ena = 1'b1; enb = 1'b1; addra = 32'(i); addrb = 32'(i + 8);
      @(posedge clk);
      if (i < 3) @(negedge clk);
    end
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < N; k++) begin
      checks++;
      if ({doa[k], dob[k], vlda[k], vldb[k]} !== '0) begin
        failures++;
        $display("[TB] FAIL reset_immediate inst=%0d got doa=%h dob=%h vlda=%b vldb=%b want all 0",
                 k, doa[k], dob[k], vlda[k], vldb[k]);
      end
    end
    @(negedge clk);
    wea = 8'hFF; addra = 32'h3; dia = 64'hBAD0_BAD0_BAD0_BAD0;
    web = 8'hFF; addrb = 32'h9; dib = 64'hBAD1_BAD1_BAD1_BAD1;
    repeat (2) @(negedge clk);
    for (int k = 0; k < N; k++) begin
      checks++;
      if ({doa[k], dob[k], vlda[k], vldb[k]} !== '0) begin
        failures++;
        $display("[TB] FAIL reset_held inst=%0d got doa=%h dob=%h vlda=%b vldb=%b want all 0",
                 k, doa[k], dob[k], vlda[k], vldb[k]);
      end
    end
    rst_n = 1'b1;
    ena = 1'b0; enb = 1'b0; wea = '0; web = '0;
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      checks++;
      if (vlda[k] !== 1'b0 || vldb[k] !== 1'b0) begin
        failures++;
        $display("[TB] FAIL post_release_idle inst=%0d got vlda=%b vldb=%b want 0/0",
                 k, vlda[k], vldb[k]);
      end
    end
    access(1'b1, 8'h00, 32'h3, 64'h0, 1'b1, 8'h00, 32'h9, 64'h0);
    capture();
    for (int k = 0; k < N; k++) begin
      checks++;
      if (cap_doa[k] !== pat(3) || cap_dob[k] !== pat(9)) begin
        failures++;
        $display("[TB] FAIL retained_data inst=%0d got doa=%h dob=%h want %h/%h",
                 k, cap_doa[k], cap_dob[k], pat(3), pat(9));
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_write_read();
    test_same_port();
    test_cross_port();
    test_collision();
    test_disable_alias();
    test_back_to_back();
    test_reset_mid_stream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
